fp_to_int: RTL and testbench

Sequential IEEE-754 single-precision to signed 32-bit integer converter; the consumer of the float words our FP adder produces.
- Unpacks sign, exponent and mantissa, then aligns the mantissa with an iterative shifter (SHIFT_STEP bits/cycle).
- Rounds, applies the sign and saturates; reports invalid/overflow/inexact flags.
- Valid/ready on both sides; one conversion in flight.

---
 rtl/fp_pkg.sv | 31 +++
 rtl/fp_unpack.sv | 30 +++
 rtl/fp_to_int.sv | 205 ++++++++++++++++++++
 tb/tb_fp_to_int.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// ----------------------------------------------------------------------------
// fp_pkg : shared IEEE-754 single-precision field widths, limits, FSM states
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package fp_pkg;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;

  localparam logic [EXP_W-1:0] FP_BIAS  = 8'd127;
  localparam logic [EXP_W-1:0] EXP_HALF = 8'd126;  // e == -1
  localparam logic [EXP_W-1:0] EXP_UNIT = 8'd150;  // e == 23, mantissa LSB has weight 1
  localparam logic [EXP_W-1:0] EXP_SAT  = 8'd158;  // e == 31

  localparam logic [31:0] INT32_MAX    = 32'h7FFF_FFFF;
  localparam logic [31:0] INT32_MIN    = 32'h8000_0000;
  localparam logic [31:0] FP_INT32_MIN = 32'hCF00_0000;  // -2^31 as a float

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DECODE = 3'd1,
    S_SHIFT  = 3'd2,
    S_ROUND  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/fp_unpack.sv
// ----------------------------------------------------------------------------
// fp_unpack : combinational split of a single-precision word into fields/classes
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fp_unpack
  import fp_pkg::*;
(
  input  logic [31:0]      fp,
  output logic             sign,
  output logic [EXP_W-1:0] exp,
  output logic [MAN_W-1:0] frac,
  output logic             hidden,
  output logic             is_nan,
  output logic             is_inf,
  output logic             is_zero
);

  assign sign    = fp[31];
  assign exp     = fp[30:23];
  assign frac    = fp[22:0];
  assign hidden  = |exp;
  assign is_nan  = (&exp) & (|frac);
  assign is_inf  = (&exp) & ~(|frac);
  assign is_zero = ~(|exp) & ~(|frac);

endmodule

`default_nettype wire

// File: rtl/fp_to_int.sv
// ----------------------------------------------------------------------------
// fp_to_int : sequential float32 -> int32 converter; define ROUND_NEAREST_EN for RNE
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fp_to_int
  import fp_pkg::*;
#(
  parameter int SHIFT_STEP = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_invalid,
  output logic        out_overflow,
  output logic        out_inexact
);

  localparam logic [4:0] STEP_V = 5'(SHIFT_STEP);

  state_t      r_state;
  logic [31:0] r_data;
  logic [31:0] r_mag;
  logic [31:0] r_res;
  logic [4:0]  r_count;
  logic        r_sign;
  logic        r_left;
  logic        r_guard;
  logic        r_sticky;
  logic        r_in_ready;
  logic        r_out_valid;
  logic        r_invalid;
  logic        r_overflow;
  logic        r_inexact;

  logic             w_sign;
  logic [EXP_W-1:0] w_exp;
  logic [MAN_W-1:0] w_frac;
  logic             w_hidden;
  logic             w_is_nan;
  logic             w_is_inf;
  logic             w_is_zero;

  fp_unpack u_unpack (
    .fp      (r_data),
    .sign    (w_sign),
    .exp     (w_exp),
    .frac    (w_frac),
    .hidden  (w_hidden),
    .is_nan  (w_is_nan),
    .is_inf  (w_is_inf),
    .is_zero (w_is_zero)
  );

  // Decode: classify the captured word and derive the alignment shift.
  logic [31:0] w_sat;
  logic        w_big;
  logic        w_dec_left;
  logic [7:0]  w_cnt8;
  logic        w_sticky_lo;

  assign w_sat       = w_sign ? INT32_MIN : INT32_MAX;
  assign w_big       = (w_exp >= EXP_SAT) && (r_data != FP_INT32_MIN);
  assign w_dec_left  = (w_exp > EXP_UNIT);
  assign w_cnt8      = w_dec_left ? (w_exp - EXP_UNIT) : (EXP_UNIT - w_exp);
  assign w_sticky_lo = (w_exp == EXP_HALF) ? (|w_frac) : !w_is_zero;

  // Shift: at most SHIFT_STEP positions per cycle, remainder on the last step.
  logic [4:0]  w_amt;
  logic [31:0] w_gbit;
  logic [31:0] w_mag_r;
  logic [31:0] w_mag_l;
  logic        w_guard_n;
  logic        w_sticky_n;

  assign w_amt      = (r_count < STEP_V) ? r_count : STEP_V;
  assign w_gbit     = 32'd1 << (w_amt - 5'd1);
  assign w_mag_r    = r_mag >> w_amt;
  assign w_mag_l    = r_mag << w_amt;
  assign w_guard_n  = |(r_mag & w_gbit);
  assign w_sticky_n = r_sticky | r_guard | (|(r_mag & (w_gbit - 32'd1)));

  logic [31:0] w_mag_fin;
  logic        w_rnd_ovf;
  logic [31:0] w_res;

`ifdef ROUND_NEAREST_EN
  logic        w_inc;
  logic [32:0] w_mag_rnd;

  assign w_inc     = r_guard & (r_sticky | r_mag[0]);
  assign w_mag_rnd = {1'b0, r_mag} + {32'd0, w_inc};
  assign w_rnd_ovf = r_sign ? (w_mag_rnd > {1'b0, INT32_MIN}) : (w_mag_rnd > {1'b0, INT32_MAX});
  assign w_mag_fin = w_mag_rnd[31:0];
`else
  assign w_rnd_ovf = 1'b0;
  assign w_mag_fin = r_mag;
`endif

  assign w_res = r_sign ? (32'd0 - w_mag_fin) : w_mag_fin;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_data      <= 32'd0;
      r_mag       <= 32'd0;
      r_res       <= 32'd0;
      r_count     <= 5'd0;
      r_sign      <= 1'b0;
      r_left      <= 1'b0;
      r_guard     <= 1'b0;
      r_sticky    <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_invalid   <= 1'b0;
      r_overflow  <= 1'b0;
      r_inexact   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_data     <= in_data;
            r_in_ready <= 1'b0;
            r_state    <= S_DECODE;
          end
        end
        S_DECODE: begin
          r_sign     <= w_sign;
          r_invalid  <= 1'b0;
          r_overflow <= 1'b0;
          r_inexact  <= 1'b0;
          if (w_is_nan) begin
            r_res       <= INT32_MIN;
            r_invalid   <= 1'b1;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else if (w_is_inf || w_big) begin
            r_res       <= w_sat;
            r_overflow  <= 1'b1;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else if (w_exp < FP_BIAS) begin
            // |value| < 1: integer part is zero, only rounding info survives
            r_mag    <= 32'd0;
            r_guard  <= (w_exp == EXP_HALF);
            r_sticky <= w_sticky_lo;
            r_count  <= 5'd0;
            r_state  <= S_ROUND;
          end else begin
            r_mag    <= {8'd0, w_hidden, w_frac};
            r_guard  <= 1'b0;
            r_sticky <= 1'b0;
            r_left   <= w_dec_left;
            r_count  <= w_cnt8[4:0];
            r_state  <= (w_cnt8 == 8'd0) ? S_ROUND : S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_mag <= r_left ? w_mag_l : w_mag_r;
          if (!r_left) begin
            r_guard  <= w_guard_n;
            r_sticky <= w_sticky_n;
          end
          r_count <= r_count - w_amt;
          if (r_count == w_amt) begin
            r_state <= S_ROUND;
          end
        end
        S_ROUND: begin
          r_res       <= w_rnd_ovf ? w_sat : w_res;
          r_overflow  <= w_rnd_ovf;
          r_inexact   <= (r_guard | r_sticky) & !w_rnd_ovf;
          r_out_valid <= 1'b1;
          r_state     <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready     = r_in_ready;
  assign out_valid    = r_out_valid;
  assign out_data     = r_res;
  assign out_invalid  = r_invalid;
  assign out_overflow = r_overflow;
  assign out_inexact  = r_inexact;

endmodule

`default_nettype wire

// File: tb/tb_fp_to_int.sv
// ----------------------------------------------------------------------------
// tb_fp_to_int : directed self-checking bench for fp_to_int
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_fp_to_int;

  localparam int STEP = 1;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_invalid;
  logic        out_overflow;
  logic        out_inexact;

  int n_assert = 0;
  int n_fail   = 0;

  fp_to_int #(.SHIFT_STEP(STEP)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_invalid  (out_invalid),
    .out_overflow (out_overflow),
    .out_inexact  (out_inexact)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask

  function automatic int norm_lat(input int cnt);
    return 3 + (cnt + STEP - 1) / STEP;
  endfunction

  // Wait (bounded) for in_ready, present one word, and return after the accept edge.
  task automatic send(input string tag, input logic [31:0] din);
    int w;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (w >= 100) check_bit({tag, "_ready_timeout"}, in_ready, 1'b1);
    in_valid = 1'b1;
    in_data  = din;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 32'hDEAD_BEEF;
  endtask

  // Count negedges after the accept edge until out_valid; j equals k+j in the latency spec.
  task automatic wait_result(input string tag, output int j);
    j = 0;
    do begin
      @(negedge clk);
      j++;
    end while (!out_valid && j < 200);
    if (j >= 200) check_bit({tag, "_valid_timeout"}, out_valid, 1'b1);
  endtask

  task automatic conv(input string tag, input logic [31:0] din, input logic [31:0] exp_d,
                      input logic e_inv, input logic e_ovf, input logic e_inx, input int exp_lat);
    int j;
    send(tag, din);
    wait_result(tag, j);
    if (exp_lat > 0) check({tag, "_latency"}, 32'(j), 32'(exp_lat));
    check({tag, "_data"}, out_data, exp_d);
    check_bit({tag, "_invalid"}, out_invalid, e_inv);
    check_bit({tag, "_overflow"}, out_overflow, e_ovf);
    check_bit({tag, "_inexact"}, out_inexact, e_inx);
    check_bit({tag, "_in_ready_busy"}, in_ready, 1'b0);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check_bit({tag, "_valid_drop"}, out_valid, 1'b0);
  endtask

  initial begin
    int j;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 32'd0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_bit("rst_in_ready", in_ready, 1'b1);
    check_bit("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 32'd0);
    check_bit("rst_invalid", out_invalid, 1'b0);
    check_bit("rst_overflow", out_overflow, 1'b0);
    check_bit("rst_inexact", out_inexact, 1'b0);
    rst_n = 1'b1;

    // e=2 -> right shift 21; e=3 -> right shift 20
    conv("six",     32'h40C0_0000, 32'h0000_0006, 1'b0, 1'b0, 1'b0, norm_lat(21));
    conv("neg8",    32'hC100_0000, 32'hFFFF_FFF8, 1'b0, 1'b0, 1'b0, norm_lat(20));
    conv("one",     32'h3F80_0000, 32'h0000_0001, 1'b0, 1'b0, 1'b0, norm_lat(23));
`ifdef ROUND_NEAREST_EN
    conv("p9_75",   32'h411C_0000, 32'h0000_000A, 1'b0, 1'b0, 1'b1, norm_lat(20));
    conv("p0_5625", 32'h3F10_0000, 32'h0000_0001, 1'b0, 1'b0, 1'b1, 3);
    conv("p2_5",    32'h4020_0000, 32'h0000_0002, 1'b0, 1'b0, 1'b1, norm_lat(22));
    conv("p3_5",    32'h4060_0000, 32'h0000_0004, 1'b0, 1'b0, 1'b1, norm_lat(22));
    conv("m1_5",    32'hBFC0_0000, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1, norm_lat(23));
`else
    conv("p9_75",   32'h411C_0000, 32'h0000_0009, 1'b0, 1'b0, 1'b1, norm_lat(20));
    conv("p0_5625", 32'h3F10_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 3);
    conv("p2_5",    32'h4020_0000, 32'h0000_0002, 1'b0, 1'b0, 1'b1, norm_lat(22));
    conv("p3_5",    32'h4060_0000, 32'h0000_0003, 1'b0, 1'b0, 1'b1, norm_lat(22));
    conv("m1_5",    32'hBFC0_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, norm_lat(23));
`endif
    conv("neg_zero", 32'h8000_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 3);
    conv("denorm",   32'h0000_0001, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 3);
    conv("max_fin",  32'h4EFF_FFFF, 32'h7FFF_FF80, 1'b0, 1'b0, 1'b0, norm_lat(7));
    conv("two31",    32'h4F00_0000, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0, 2);
    conv("min_int",  32'hCF00_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b0, norm_lat(8));
    conv("neg_inf",  32'hFF80_0000, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 2);
    conv("nan",      32'h7FC0_0000, 32'h8000_0000, 1'b1, 1'b0, 1'b0, 2);

    // Backpressure: result held for 10 cycles while a new word waits at the input.
    send("bp", 32'h40C0_0000);
    in_valid = 1'b1;
    in_data  = 32'hC100_0000;
    wait_result("bp", j);
    repeat (10) begin
      @(negedge clk);
      check_bit("bp_hold_valid", out_valid, 1'b1);
      check("bp_hold_data", out_data, 32'h0000_0006);
      check_bit("bp_hold_in_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_bit("bp_release_valid", out_valid, 1'b0);
    check_bit("bp_release_in_ready", in_ready, 1'b1);
    @(negedge clk);
    check_bit("bp_next_accepted", in_ready, 1'b0);
    in_valid = 1'b0;
    wait_result("bp_next", j);
    check("bp_next_latency", 32'(j), 32'(norm_lat(20) - 1));
    check("bp_next_data", out_data, 32'hFFFF_FFF8);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Reset pulse while the shifter is busy.
    send("rst_mid", 32'h40C0_0000);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_bit("rst_mid_in_ready", in_ready, 1'b1);
    check_bit("rst_mid_out_valid", out_valid, 1'b0);
    check("rst_mid_out_data", out_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check_bit("rst_mid_no_stale", out_valid, 1'b0);
`ifdef ROUND_NEAREST_EN
    conv("after_rst", 32'h411C_0000, 32'h0000_000A, 1'b0, 1'b0, 1'b1, norm_lat(20));
`else
    conv("after_rst", 32'h411C_0000, 32'h0000_0009, 1'b0, 1'b0, 1'b1, norm_lat(20));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
